// File: rtl/fpu_normalize.sv
// Two-stage normalization pipeline between the FP add/sub/mul datapath and fpu_round.
// Stage 1 registers the raw beat and its leading-zero count; stage 2 shifts and adjusts the exponent.
module fpu_normalize #(
   parameter int unsigned EXPONENT_WIDTH    = 11,
   parameter int unsigned SIGNIFICAND_WIDTH = 52,
   localparam int unsigned RAW_WIDTH        = SIGNIFICAND_WIDTH + 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_sign,
   input  logic [EXPONENT_WIDTH:0]      in_exponent,
   input  logic [RAW_WIDTH-1:0]         in_significand,
   input  logic                         in_sticky,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_sign,
   output logic [EXPONENT_WIDTH-1:0]    out_exponent,
   output logic [SIGNIFICAND_WIDTH:0]   out_significand,
   output logic                         guard,
   output logic                         round,
   output logic                         sticky,
   output logic                         out_zero,
   output logic                         out_overflow
);

   localparam int unsigned EW  = EXPONENT_WIDTH;
   localparam int unsigned SW  = SIGNIFICAND_WIDTH;
   localparam int unsigned NW  = SW + 3;
   localparam int unsigned LZW = $clog2(SW + 4);
   localparam int unsigned XW  = EW + 2;
   localparam logic [XW-1:0] ExpMax = {2'b00, {EW{1'b1}}};
   localparam logic [EW:0]   ExpOne = {{EW{1'b0}}, 1'b1};

   logic              s1_valid_q, s1_valid_d;
   logic              s1_sign_q, s1_sign_d;
   logic [EW:0]       s1_exp_q, s1_exp_d;
   logic [RAW_WIDTH-1:0] s1_sig_q, s1_sig_d;
   logic              s1_sticky_q, s1_sticky_d;
   logic [LZW-1:0]    s1_lzc_q, s1_lzc_d;

   logic              s2_valid_q, s2_valid_d;
   logic              s2_sign_q, s2_sign_d;
   logic [EW-1:0]     s2_exp_q, s2_exp_d;
   logic [SW:0]       s2_sig_q, s2_sig_d;
   logic              s2_guard_q, s2_guard_d;
   logic              s2_round_q, s2_round_d;
   logic              s2_sticky_q, s2_sticky_d;
   logic              s2_zero_q, s2_zero_d;
   logic              s2_ovf_q, s2_ovf_d;

   logic              s2_adv, s1_load;
   logic [LZW-1:0]    lzc;
   logic [NW-1:0]     low, norm_n;
   logic [XW-1:0]     exp_x, lzc_x, norm_exp;
   logic              drop, sticky_n, ovf;

   assign s2_adv   = !s2_valid_q || out_ready;
   assign in_ready = rst_n && (!s1_valid_q || s2_adv);
   assign s1_load  = in_valid && in_ready;

   // Highest set bit wins because the scan runs upward.
   always_comb begin
      lzc = LZW'(NW);
      for (int i = 0; i < int'(NW); i++) begin
         if (in_significand[i]) lzc = LZW'(int'(NW) - 1 - i);
      end
   end

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_sign_d   = s1_sign_q;
      s1_exp_d    = s1_exp_q;
      s1_sig_d    = s1_sig_q;
      s1_sticky_d = s1_sticky_q;
      s1_lzc_d    = s1_lzc_q;
      if (in_ready) s1_valid_d = in_valid;
      if (s1_load) begin
         s1_sign_d   = in_sign;
         s1_exp_d    = in_exponent;
         s1_sig_d    = in_significand;
         s1_sticky_d = in_sticky;
         s1_lzc_d    = lzc;
      end
   end

   always_comb begin
      exp_x    = XW'(s1_exp_q);
      lzc_x    = XW'(s1_lzc_q);
      low      = s1_sig_q[NW-1:0];
      norm_n   = low;
      norm_exp = exp_x;
      drop     = 1'b0;
      if (s1_sig_q[NW]) begin
         norm_n   = s1_sig_q[NW:1];
         norm_exp = exp_x + XW'(1);
         drop     = s1_sig_q[0];
      end else if (low == '0) begin
         norm_n   = '0;
         norm_exp = '0;
      end else if (exp_x == '0) begin
         norm_exp = '0;
      end else if (exp_x > lzc_x) begin
         norm_n   = low << s1_lzc_q;
         norm_exp = exp_x - lzc_x;
      end else begin
         // Shift only as far as the minimum exponent allows; result is subnormal.
         norm_n   = low << (s1_exp_q - ExpOne);
         norm_exp = '0;
      end
      sticky_n = s1_sticky_q | drop;
      ovf      = norm_exp >= ExpMax;
   end

   always_comb begin
      s2_valid_d  = s2_valid_q;
      s2_sign_d   = s2_sign_q;
      s2_exp_d    = s2_exp_q;
      s2_sig_d    = s2_sig_q;
      s2_guard_d  = s2_guard_q;
      s2_round_d  = s2_round_q;
      s2_sticky_d = s2_sticky_q;
      s2_zero_d   = s2_zero_q;
      s2_ovf_d    = s2_ovf_q;
      if (s2_adv) s2_valid_d = s1_valid_q;
      if (s2_adv && s1_valid_q) begin
         s2_sign_d   = s1_sign_q;
         s2_exp_d    = ovf ? {EW{1'b1}} : norm_exp[EW-1:0];
         s2_sig_d    = norm_n[NW-1:2];
         s2_guard_d  = norm_n[1];
         s2_round_d  = norm_n[0];
         s2_sticky_d = sticky_n;
         s2_zero_d   = (norm_n == '0) && !sticky_n;
         s2_ovf_d    = ovf;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_sign_q   <= 1'b0;
         s1_exp_q    <= '0;
         s1_sig_q    <= '0;
         s1_sticky_q <= 1'b0;
         s1_lzc_q    <= '0;
         s2_valid_q  <= 1'b0;
         s2_sign_q   <= 1'b0;
         s2_exp_q    <= '0;
         s2_sig_q    <= '0;
         s2_guard_q  <= 1'b0;
         s2_round_q  <= 1'b0;
         s2_sticky_q <= 1'b0;
         s2_zero_q   <= 1'b0;
         s2_ovf_q    <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_sign_q   <= s1_sign_d;
         s1_exp_q    <= s1_exp_d;
         s1_sig_q    <= s1_sig_d;
         s1_sticky_q <= s1_sticky_d;
         s1_lzc_q    <= s1_lzc_d;
         s2_valid_q  <= s2_valid_d;
         s2_sign_q   <= s2_sign_d;
         s2_exp_q    <= s2_exp_d;
         s2_sig_q    <= s2_sig_d;
         s2_guard_q  <= s2_guard_d;
         s2_round_q  <= s2_round_d;
         s2_sticky_q <= s2_sticky_d;
         s2_zero_q   <= s2_zero_d;
         s2_ovf_q    <= s2_ovf_d;
      end
   end

   assign out_valid       = s2_valid_q;
   assign out_sign        = s2_sign_q;
   assign out_exponent    = s2_exp_q;
   assign out_significand = s2_sig_q;
   assign guard           = s2_guard_q;
   assign round           = s2_round_q;
   assign sticky          = s2_sticky_q;
   assign out_zero        = s2_zero_q;
   assign out_overflow    = s2_ovf_q;

endmodule

// File: tb/tb_fpu_normalize.sv
// Directed bench for fpu_normalize with EXPONENT_WIDTH=5, SIGNIFICAND_WIDTH=10.
// Observed outputs are packed as {valid, sign, exp, sig, guard, round, sticky, zero, overflow}.
module tb_fpu_normalize;

   localparam int unsigned EW = 5;
   localparam int unsigned SW = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          in_sign = 1'b0;
   logic [EW:0]   in_exponent = '0;
   logic [SW+3:0] in_significand = '0;
   logic          in_sticky = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic          out_sign;
   logic [EW-1:0] out_exponent;
   logic [SW:0]   out_significand;
   logic          guard, round, sticky, out_zero, out_overflow;

   logic [22:0]   obs;
   int            n_checks = 0;
   int            n_fail = 0;

   assign obs = {out_valid, out_sign, out_exponent, out_significand,
                 guard, round, sticky, out_zero, out_overflow};

   fpu_normalize #(
      .EXPONENT_WIDTH   (EW),
      .SIGNIFICAND_WIDTH(SW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_sign        (in_sign),
      .in_exponent    (in_exponent),
      .in_significand (in_significand),
      .in_sticky      (in_sticky),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_sign       (out_sign),
      .out_exponent   (out_exponent),
      .out_significand(out_significand),
      .guard          (guard),
      .round          (round),
      .sticky         (sticky),
      .out_zero       (out_zero),
      .out_overflow   (out_overflow)
   );

   always #5 clk = ~clk;

   // Expected beats: {valid, sign, exp[4:0], sig[10:0], g, r, s, zero, ovf}
   localparam logic [22:0] ExpLeft  = {1'b1, 1'b0, 5'd13, 11'h400, 5'b00000};
   localparam logic [22:0] ExpCarry = {1'b1, 1'b0, 5'd16, 11'h400, 5'b00100};
   localparam logic [22:0] ExpSub   = {1'b1, 1'b0, 5'd0,  11'h080, 5'b00000};

   task automatic drive(input logic s, input logic [EW:0] e, input logic [SW+3:0] sig,
                        input logic st);
      in_valid       = 1'b1;
      in_sign        = s;
      in_exponent    = e;
      in_significand = sig;
      in_sticky      = st;
   endtask

   task automatic idle();
      in_valid       = 1'b0;
      in_significand = '0;
   endtask

   // Single beat with out_ready=1; returns at the negedge where the result is visible.
   task automatic run_beat(input logic s, input logic [EW:0] e, input logic [SW+3:0] sig,
                           input logic st);
      @(negedge clk);
      drive(s, e, sig, st);
      @(posedge clk);
      @(negedge clk);
      idle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (obs !== 23'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h expected %h", obs, 23'd0);
      end
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %b expected 0", in_ready);
      end
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL release_in_ready: got %b expected 1", in_ready);
      end
   endtask

   task automatic test_carry();
      run_beat(1'b0, 6'd15, 14'h2001, 1'b0);
      n_checks++;
      if (obs !== ExpCarry) begin
         n_fail++;
         $display("FAIL carry: got %h expected %h", obs, ExpCarry);
      end
      run_beat(1'b0, 6'd15, 14'h2007, 1'b0);
      n_checks++;
      if (obs !== {1'b1, 1'b0, 5'd16, 11'h400, 5'b11100}) begin
         n_fail++;
         $display("FAIL carry_guard_round: got %h expected %h", obs,
                  {1'b1, 1'b0, 5'd16, 11'h400, 5'b11100});
      end
   endtask

   task automatic test_left();
      run_beat(1'b1, 6'd15, 14'h0400, 1'b0);
      n_checks++;
      if (obs !== {1'b1, 1'b1, 5'd13, 11'h400, 5'b00000}) begin
         n_fail++;
         $display("FAIL left_norm: got %h expected %h", obs,
                  {1'b1, 1'b1, 5'd13, 11'h400, 5'b00000});
      end
      // exp just above lzc: still a normal result with exponent 1
      run_beat(1'b0, 6'd2, 14'h0800, 1'b0);
      n_checks++;
      if (obs !== {1'b1, 1'b0, 5'd1, 11'h400, 5'b00000}) begin
         n_fail++;
         $display("FAIL left_norm_min: got %h expected %h", obs,
                  {1'b1, 1'b0, 5'd1, 11'h400, 5'b00000});
      end
   endtask

   task automatic test_subnormal();
      run_beat(1'b0, 6'd2, 14'h0100, 1'b0);
      n_checks++;
      if (obs !== ExpSub) begin
         n_fail++;
         $display("FAIL subnormal: got %h expected %h", obs, ExpSub);
      end
      run_beat(1'b0, 6'd4, 14'h0100, 1'b0);
      n_checks++;
      if (obs !== {1'b1, 1'b0, 5'd0, 11'h200, 5'b00000}) begin
         n_fail++;
         $display("FAIL subnormal_eq_lzc: got %h expected %h", obs,
                  {1'b1, 1'b0, 5'd0, 11'h200, 5'b00000});
      end
      run_beat(1'b0, 6'd0, 14'h0403, 1'b1);
      n_checks++;
      if (obs !== {1'b1, 1'b0, 5'd0, 11'h100, 5'b11100}) begin
         n_fail++;
         $display("FAIL exp_zero: got %h expected %h", obs,
                  {1'b1, 1'b0, 5'd0, 11'h100, 5'b11100});
      end
   endtask

   task automatic test_zero();
      run_beat(1'b0, 6'd10, 14'h0000, 1'b0);
      n_checks++;
      if (obs !== {1'b1, 1'b0, 5'd0, 11'h000, 5'b00010}) begin
         n_fail++;
         $display("FAIL zero: got %h expected %h", obs, {1'b1, 1'b0, 5'd0, 11'h000, 5'b00010});
      end
      run_beat(1'b0, 6'd10, 14'h0000, 1'b1);
      n_checks++;
      if (obs !== {1'b1, 1'b0, 5'd0, 11'h000, 5'b00100}) begin
         n_fail++;
         $display("FAIL zero_sticky: got %h expected %h", obs,
                  {1'b1, 1'b0, 5'd0, 11'h000, 5'b00100});
      end
   endtask

   task automatic test_overflow();
      run_beat(1'b0, 6'd30, 14'h2000, 1'b0);
      n_checks++;
      if (obs !== {1'b1, 1'b0, 5'd31, 11'h400, 5'b00001}) begin
         n_fail++;
         $display("FAIL ovf_carry: got %h expected %h", obs,
                  {1'b1, 1'b0, 5'd31, 11'h400, 5'b00001});
      end
      run_beat(1'b0, 6'd40, 14'h1000, 1'b0);
      n_checks++;
      if (obs !== {1'b1, 1'b0, 5'd31, 11'h400, 5'b00001}) begin
         n_fail++;
         $display("FAIL ovf_wide_exp: got %h expected %h", obs,
                  {1'b1, 1'b0, 5'd31, 11'h400, 5'b00001});
      end
      run_beat(1'b0, 6'd30, 14'h1000, 1'b0);
      n_checks++;
      if (obs !== {1'b1, 1'b0, 5'd30, 11'h400, 5'b00000}) begin
         n_fail++;
         $display("FAIL ovf_boundary: got %h expected %h", obs,
                  {1'b1, 1'b0, 5'd30, 11'h400, 5'b00000});
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      @(negedge clk);
      drive(1'b0, 6'd15, 14'h0400, 1'b0);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 6'd15, 14'h2001, 1'b0);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 6'd2, 14'h0100, 1'b0);
      n_checks++;
      if ({in_ready, obs} !== {1'b1, ExpLeft}) begin
         n_fail++;
         $display("FAIL b2b_first: got %h expected %h", {in_ready, obs}, {1'b1, ExpLeft});
      end
      @(posedge clk);
      @(negedge clk);
      idle();
      n_checks++;
      if (obs !== ExpCarry) begin
         n_fail++;
         $display("FAIL b2b_second: got %h expected %h", obs, ExpCarry);
      end
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (obs !== ExpSub) begin
         n_fail++;
         $display("FAIL b2b_third: got %h expected %h", obs, ExpSub);
      end
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_drain: got %b expected 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      @(negedge clk);
      drive(1'b0, 6'd15, 14'h0400, 1'b0);
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_ready_a: got %b expected 1", in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 6'd15, 14'h2001, 1'b0);
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_ready_b: got %b expected 1", in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 6'd2, 14'h0100, 1'b0);
      n_checks++;
      if ({in_ready, obs} !== {1'b0, ExpLeft}) begin
         n_fail++;
         $display("FAIL bp_full: got %h expected %h", {in_ready, obs}, {1'b0, ExpLeft});
      end
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({in_ready, obs} !== {1'b0, ExpLeft}) begin
         n_fail++;
         $display("FAIL bp_stable: got %h expected %h", {in_ready, obs}, {1'b0, ExpLeft});
      end
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_ready_comb: got %b expected 1", in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      idle();
      n_checks++;
      if (obs !== ExpCarry) begin
         n_fail++;
         $display("FAIL bp_second: got %h expected %h", obs, ExpCarry);
      end
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (obs !== ExpSub) begin
         n_fail++;
         $display("FAIL bp_third: got %h expected %h", obs, ExpSub);
      end
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_drain: got %b expected 0", out_valid);
      end
   endtask

   task automatic test_reset_midflight();
      out_ready = 1'b1;
      @(negedge clk);
      drive(1'b0, 6'd15, 14'h0400, 1'b0);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 6'd15, 14'h2001, 1'b0);
      @(posedge clk);
      @(negedge clk);
      idle();
      n_checks++;
      if (obs !== ExpLeft) begin
         n_fail++;
         $display("FAIL mid_inflight: got %h expected %h", obs, ExpLeft);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({in_ready, obs} !== 24'd0) begin
         n_fail++;
         $display("FAIL mid_reset: got %h expected %h", {in_ready, obs}, 24'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_release_ready: got %b expected 1", in_ready);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_no_stale[%0d]: got %b expected 0", i, out_valid);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_carry();
      test_left();
      test_subnormal();
      test_zero();
      test_overflow();
      test_back_to_back();
      test_backpressure();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
